xfcp_wb_arb_2: RTL and testbench

Two-master Wishbone arbiter that shares one Wishbone slave port between two masters, e.g. an xfcp_mod_wb instance and a local CPU/DMA master. Grants the bus per cycle (cyc-framed) using round-robin or fixed priority. Holds the grant until the owner drops cyc. Includes a watchdog that aborts hung transfers with err, so an unresponsive slave cannot lock out the XFCP debug path.

---
 rtl/xfcp_wb_arb_2.sv | 161 ++++++++++++++++
 tb/tb_xfcp_wb_arb_2.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfcp_wb_arb_2.sv
// Two-master Wishbone arbiter sharing one slave port, with cyc-framed grants
// and a watchdog that aborts stalled strobes with err.
module xfcp_wb_arb_2 #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ARB_ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT         = 1024,
  parameter int unsigned TIMEOUT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  input  logic                    wbm0_cyc_i,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  input  logic                    wbm1_cyc_i,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  output logic                    wbs_cyc_o
);

  typedef enum logic [1:0] {GrNone, Gr0, Gr1} grant_e;

  localparam bit WdEnable = (TIMEOUT != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WdLast =
      WdEnable ? TIMEOUT_WIDTH'(TIMEOUT - 1) : '0;

  grant_e                   grant_q, grant_d;
  logic                     last_grant_q, last_grant_d;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  logic owner_cyc;
  logic owner_stb;
  logic abort;

  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    unique case (grant_q)
      Gr0: begin
        owner_cyc = wbm0_cyc_i;
        owner_stb = wbm0_stb_i;
      end
      Gr1: begin
        owner_cyc = wbm1_cyc_i;
        owner_stb = wbm1_stb_i;
      end
      default: ;
    endcase
  end

  // Abort fires on the TIMEOUT-th consecutive unanswered strobe cycle.
  assign abort = WdEnable && owner_cyc && owner_stb && (wd_cnt_q == WdLast);

  // Re-arbitrate when idle or when the owner has let go of cyc; a waiting
  // master takes over on that same edge.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (grant_q == GrNone || !owner_cyc) begin
      if (wbm0_cyc_i && wbm1_cyc_i) begin
        if (ARB_ROUND_ROBIN != 0 && !last_grant_q) begin
          grant_d = Gr1;
        end else begin
          grant_d = Gr0;
        end
      end else if (wbm0_cyc_i) begin
        grant_d = Gr0;
      end else if (wbm1_cyc_i) begin
        grant_d = Gr1;
      end else begin
        grant_d = GrNone;
      end
      if (grant_d != GrNone) begin
        last_grant_d = (grant_d == Gr1);
      end
    end
  end

  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_sel_o  = '0;
    wbs_cyc_o  = 1'b0;
    wbm0_dat_o = '0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm1_dat_o = '0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    unique case (grant_q)
      Gr0: begin
        wbs_adr_o  = wbm0_adr_i;
        wbs_dat_o  = wbm0_dat_i;
        wbs_we_o   = wbm0_we_i;
        wbs_sel_o  = wbm0_sel_i;
        wbs_cyc_o  = wbm0_cyc_i;
        wbm0_dat_o = wbs_dat_i;
        wbm0_ack_o = wbs_ack_i;
        wbm0_err_o = wbs_err_i | abort;
      end
      Gr1: begin
        wbs_adr_o  = wbm1_adr_i;
        wbs_dat_o  = wbm1_dat_i;
        wbs_we_o   = wbm1_we_i;
        wbs_sel_o  = wbm1_sel_i;
        wbs_cyc_o  = wbm1_cyc_i;
        wbm1_dat_o = wbs_dat_i;
        wbm1_ack_o = wbs_ack_i;
        wbm1_err_o = wbs_err_i | abort;
      end
      default: ;
    endcase
  end

  assign wbs_stb_o = owner_stb & owner_cyc & ~abort;

  always_comb begin
    wd_cnt_d = '0;
    if (WdEnable && grant_d == grant_q && wbs_stb_o && !wbs_ack_i && !wbs_err_i) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= GrNone;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_xfcp_wb_arb_2.sv
// Bench for xfcp_wb_arb_2: a round-robin instance (TIMEOUT=8) and a
// fixed-priority instance (watchdog off) share stimulus and are checked
// every cycle against a transaction-level reference model.
module tb_xfcp_wb_arb_2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int BW = AW + DW + SW + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic [1:0]    m_we, m_cyc, m_stb;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;

  logic [AW-1:0] o_adr  [2];
  logic [DW-1:0] o_wdat [2];
  logic [SW-1:0] o_sel  [2];
  logic [1:0]    o_we, o_stb, o_cyc;
  logic [DW-1:0] o_rdat [2][2];
  logic [1:0]    o_ack  [2];
  logic [1:0]    o_err  [2];

  xfcp_wb_arb_2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                  .ARB_ROUND_ROBIN(1), .TIMEOUT(8), .TIMEOUT_WIDTH(16)) dut_rr (
    .clk(clk), .rst(rst),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(o_rdat[0][0]),
    .wbm0_we_i(m_we[0]), .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]),
    .wbm0_ack_o(o_ack[0][0]), .wbm0_err_o(o_err[0][0]), .wbm0_cyc_i(m_cyc[0]),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(o_rdat[0][1]),
    .wbm1_we_i(m_we[1]), .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]),
    .wbm1_ack_o(o_ack[0][1]), .wbm1_err_o(o_err[0][1]), .wbm1_cyc_i(m_cyc[1]),
    .wbs_adr_o(o_adr[0]), .wbs_dat_i(s_dat), .wbs_dat_o(o_wdat[0]), .wbs_we_o(o_we[0]),
    .wbs_sel_o(o_sel[0]), .wbs_stb_o(o_stb[0]), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .wbs_cyc_o(o_cyc[0])
  );

  xfcp_wb_arb_2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                  .ARB_ROUND_ROBIN(0), .TIMEOUT(0), .TIMEOUT_WIDTH(16)) dut_fp (
    .clk(clk), .rst(rst),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(o_rdat[1][0]),
    .wbm0_we_i(m_we[0]), .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]),
    .wbm0_ack_o(o_ack[1][0]), .wbm0_err_o(o_err[1][0]), .wbm0_cyc_i(m_cyc[0]),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(o_rdat[1][1]),
    .wbm1_we_i(m_we[1]), .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]),
    .wbm1_ack_o(o_ack[1][1]), .wbm1_err_o(o_err[1][1]), .wbm1_cyc_i(m_cyc[1]),
    .wbs_adr_o(o_adr[1]), .wbs_dat_i(s_dat), .wbs_dat_o(o_wdat[1]), .wbs_we_o(o_we[1]),
    .wbs_sel_o(o_sel[1]), .wbs_stb_o(o_stb[1]), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .wbs_cyc_o(o_cyc[1])
  );

  // Reference model per instance: owner (-1 = none), last winner, and the
  // number of consecutive unanswered strobe cycles seen by the owner.
  int mg [2];
  int ml [2];
  int run [2];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic int tmo(int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic bit owner_strobing(int k);
    return mg[k] >= 0 && m_cyc[mg[k]] && m_stb[mg[k]];
  endfunction

  function automatic bit abort_now(int k);
    return tmo(k) > 0 && owner_strobing(k) && run[k] == tmo(k) - 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mg[k] = -1;
      ml[k] = 1;
      run[k] = 0;
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    for (int k = 0; k < 2; k++) begin
      bit ab = abort_now(k);
      logic [BW-1:0]   exp_b, got_b;
      logic [DW+1:0]   exp_m [2];
      logic [DW+1:0]   got_m;
      exp_b = '0;
      exp_m[0] = '0;
      exp_m[1] = '0;
      if (rst && mg[k] >= 0) begin
        int n = mg[k];
        exp_b = {m_adr[n], m_dat[n], m_we[n], m_sel[n], m_stb[n] & m_cyc[n] & ~ab, m_cyc[n]};
        exp_m[n] = {s_dat, s_ack, s_err | ab};
      end
      got_b = {o_adr[k], o_wdat[k], o_we[k], o_sel[k], o_stb[k], o_cyc[k]};
      n_cmp++;
      assert (got_b === exp_b) else begin
        n_bad++;
        $error("FAIL %s dut%0d slave side got=%h exp=%h", tag, k, got_b, exp_b);
      end
      for (int j = 0; j < 2; j++) begin
        got_m = {o_rdat[k][j], o_ack[k][j], o_err[k][j]};
        n_cmp++;
        assert (got_m === exp_m[j]) else begin
          n_bad++;
          $error("FAIL %s dut%0d master%0d got=%h exp=%h", tag, k, j, got_m, exp_m[j]);
        end
      end
    end
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mg[k] = -1;
        ml[k] = 1;
        run[k] = 0;
      end else begin
        bit ab = abort_now(k);
        bit strobing = owner_strobing(k);
        int prev = mg[k];
        if (prev < 0 || !m_cyc[prev]) begin
          if (m_cyc[0] && m_cyc[1]) mg[k] = (k == 0) ? 1 - ml[k] : 0;
          else if (m_cyc[0]) mg[k] = 0;
          else if (m_cyc[1]) mg[k] = 1;
          else mg[k] = -1;
          if (mg[k] >= 0) ml[k] = mg[k];
        end
        run[k] = (mg[k] == prev && strobing && !ab && !s_ack && !s_err) ? run[k] + 1 : 0;
      end
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge, then
  // return 1 time unit later so the caller can drive the next inputs.
  task automatic step(string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic set_m(int n, bit cyc, bit stb, bit we, logic [AW-1:0] adr, logic [DW-1:0] dat);
    m_cyc[n] = cyc;
    m_stb[n] = stb;
    m_we[n]  = we;
    m_adr[n] = adr;
    m_dat[n] = dat;
    m_sel[n] = 4'hF;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    model_reset();
    step("rst_pulse");
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    s_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    #1;
    check_outputs("reset_async");
    step("reset0");
    step("reset1");
    rst = 1'b1;

    // Single master write, slave acks on the third granted cycle
    set_m(0, 1, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    #1 chk("t1_cyc_before", 64'(o_cyc[0]), 64'd0);
    step("t1_req");
    #1 chk("t1_cyc_next", 64'(o_cyc[0]), 64'd1);
    chk("t1_adr", 64'(o_adr[0]), 64'h10);
    chk("t1_wdat", 64'(o_wdat[0]), 64'hDEAD_BEEF);
    step("t1_w1");
    step("t1_w2");
    s_ack = 1'b1;
    #1 chk("t1_ack0", 64'(o_ack[0][0]), 64'd1);
    chk("t1_ack1", 64'(o_ack[0][1]), 64'd0);
    step("t1_ack");
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, '0, '0);
    step("t1_idle");

    // Tie from reset, handoff without dead cycle, round-robin back to 0
    reset_pulse();
    set_m(0, 1, 1, 1, 32'h100, 32'hA0);
    set_m(1, 1, 1, 1, 32'h200, 32'hA1);
    step("t2_req");
    #1 chk("t2_first_rr", 64'(o_adr[0]), 64'h100);
    chk("t2_first_fp", 64'(o_adr[1]), 64'h100);
    s_ack = 1'b1;
    step("t2_ack0");
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, '0, '0);
    #1 chk("t2_drop_cyc", 64'(o_cyc[0]), 64'd0);
    step("t2_drop");
    #1 chk("t2_handoff", 64'(o_adr[0]), 64'h200);
    chk("t2_handoff_cyc", 64'(o_cyc[0]), 64'd1);
    s_ack = 1'b1;
    step("t2_ack1");
    s_ack = 1'b0;
    set_m(1, 0, 0, 0, '0, '0);
    step("t2_idle");
    set_m(0, 1, 1, 1, 32'h100, 32'hA0);
    set_m(1, 1, 1, 1, 32'h200, 32'hA1);
    step("t2_req2");
    #1 chk("t2_rr_back", 64'(o_adr[0]), 64'h100);

    // Owner keeps cyc across three transactions; master 1 waits throughout
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1, 1, 1, 32'h100 + i, 32'hB0 + i);
      s_ack = 1'b1;
      #1 chk("t3_hold_rr", 64'(o_adr[0]), 64'(32'h100 + i));
      chk("t3_hold_fp", 64'(o_adr[1]), 64'(32'h100 + i));
      step("t3_xfer");
      s_ack = 1'b0;
      m_stb[0] = 1'b0;
      step("t3_gap");
    end
    set_m(0, 0, 0, 0, '0, '0);
    step("t3_release");
    #1 chk("t3_m1_fp", 64'(o_adr[1]), 64'h200);
    set_m(1, 0, 0, 0, '0, '0);
    step("t3_idle0");
    step("t3_idle1");

    // Watchdog: master 1 strobes into a silent slave
    set_m(1, 1, 1, 1, 32'h300, 32'hC0);
    step("t4_req");
    for (int i = 1; i <= 9; i++) begin
      #1;
      if (i == 8) begin
        chk("t4_err", 64'(o_err[0][1]), 64'd1);
        chk("t4_stb_forced", 64'(o_stb[0]), 64'd0);
        chk("t4_grant_kept", 64'(o_adr[0]), 64'h300);
        chk("t4_fp_no_err", 64'(o_err[1][1]), 64'd0);
      end else begin
        chk("t4_no_err", 64'(o_err[0][1]), 64'd0);
      end
      step("t4_stall");
    end

    // Read data routed to the owner only
    m_we[1] = 1'b0;
    s_dat = 32'h1234_5678;
    s_ack = 1'b1;
    #1 chk("t5_m1_dat", 64'(o_rdat[0][1]), 64'h1234_5678);
    chk("t5_m0_dat", 64'(o_rdat[0][0]), 64'd0);
    chk("t5_m1_dat_fp", 64'(o_rdat[1][1]), 64'h1234_5678);
    step("t5_read");
    s_ack = 1'b0;
    s_dat = '0;

    // Asynchronous reset in the middle of a master 0 transfer
    set_m(1, 0, 0, 0, '0, '0);
    set_m(0, 1, 1, 1, 32'h400, 32'hD0);
    step("t6_handoff");
    #1 chk("t6_cyc_up", 64'(o_cyc[0]), 64'd1);
    chk("t6_stb_up", 64'(o_stb[0]), 64'd1);
    #1;
    rst = 1'b0;
    model_reset();
    #1 chk("t6_cyc_async", 64'({o_cyc[1], o_cyc[0]}), 64'd0);
    chk("t6_stb_async", 64'({o_stb[1], o_stb[0]}), 64'd0);
    step("t6_in_reset");
    rst = 1'b1;
    set_m(1, 1, 1, 1, 32'h200, 32'hA1);
    step("t6_tie_req");
    #1 chk("t6_tie_rr", 64'(o_adr[0]), 64'h400);
    chk("t6_tie_fp", 64'(o_adr[1]), 64'h400);
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    step("t6_idle");

    // Randomised traffic, with periodic silent-slave windows for the watchdog
    for (int c = 0; c < 2000; c++) begin
      bit quiet = (c % 400) >= 300;
      for (int j = 0; j < 2; j++) begin
        if (m_cyc[j]) begin
          if ($urandom_range(0, 99) < 12) m_cyc[j] = 1'b0;
        end else if ($urandom_range(0, 99) < 25) begin
          m_cyc[j] = 1'b1;
        end
        m_stb[j] = m_cyc[j] ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 10);
        m_we[j]  = 1'($urandom);
        m_adr[j] = $urandom;
        m_dat[j] = $urandom;
        m_sel[j] = SW'($urandom);
      end
      s_ack = !quiet && ($urandom_range(0, 99) < 35);
      s_err = !quiet && ($urandom_range(0, 99) < 5);
      s_dat = $urandom;
      if (c == 1234) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
